// File: rtl/spi3w_burst.sv
// 3-wire SPI burst master: one command byte, then 1..MAX_BYTES data bytes, LSB first.
// Define SPI3W_ABORT_EN to add the abort input, which cuts a burst short through HOLD and DONE.
module spi3w_burst #(
  parameter int unsigned CLK_DIV   = 1,
  parameter int unsigned MAX_BYTES = 31,
  parameter int unsigned SETUP_CYC = 4,
  parameter int unsigned HOLD_CYC  = 4
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rw,
  input  logic [7:0] cmd,
  input  logic [7:0] len,
  input  logic [7:0] wr_byte,
  output logic       wr_ack,
  output logic [7:0] rd_byte,
  output logic       rd_valid,
  output logic       busy,
  output logic       done,
  output logic       ce,
  output logic       sclk,
  output logic       sdo,
  output logic       sdo_oe,
  input  logic       sdi
`ifdef SPI3W_ABORT_EN
  ,
  input  logic       abort
`endif
);

  localparam logic [8:0] DIV_LO_LAST = 9'(CLK_DIV - 1);
  localparam logic [8:0] DIV_HALF    = 9'(CLK_DIV);
  localparam logic [8:0] DIV_LAST    = 9'(2 * CLK_DIV - 1);
  localparam logic [7:0] SETUP_LAST  = 8'(SETUP_CYC - 1);
  localparam logic [7:0] HOLD_LAST   = 8'(HOLD_CYC - 1);
  localparam logic [7:0] MAX_LEN     = 8'(MAX_BYTES);

  typedef enum logic [2:0] {IDLE, SETUP, CMD, DATA, HOLD, DONE} state_t;

  state_t     state, state_next;
  logic       rw_q;
  logic [7:0] len_q;
  logic [7:0] tx_sh;
  logic [7:0] rx_sh;
  logic [8:0] div_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] byte_cnt;
  logic [7:0] cyc_cnt;
  logic       shifting, period_end, byte_end, last_byte, sample_now, abort_req;

  assign shifting   = (state == CMD) || (state == DATA);
  assign period_end = shifting && (div_cnt == DIV_LAST);
  assign byte_end   = period_end && (bit_cnt == 3'd7);
  assign last_byte  = (byte_cnt == len_q - 8'd1);
  // sdi is taken in the last low cycle of each bit period, just before sclk rises
  assign sample_now = (state == DATA) && rw_q && (div_cnt == DIV_LO_LAST);

`ifdef SPI3W_ABORT_EN
  assign abort_req = abort && ((state == SETUP) || shifting);
`else
  assign abort_req = 1'b0;
`endif

  always_ff @(posedge sys_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SETUP;
      SETUP:   if (cyc_cnt == SETUP_LAST) state_next = CMD;
      CMD:     if (byte_end) state_next = DATA;
      DATA:    if (byte_end && last_byte) state_next = HOLD;
      HOLD:    if (cyc_cnt == HOLD_LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort_req) state_next = HOLD;
  end

  // wr_ack is asserted in the cycle whose closing edge loads the next write byte
  always_comb begin
    ce     = 1'b0;
    sclk   = 1'b0;
    sdo_oe = 1'b0;
    wr_ack = 1'b0;
    busy   = (state != IDLE);
    done   = (state == DONE);
    case (state)
      SETUP, HOLD: ce = 1'b1;
      CMD: begin
        ce     = 1'b1;
        sclk   = (div_cnt >= DIV_HALF);
        sdo_oe = 1'b1;
        wr_ack = !rw_q && byte_end && !abort_req;
      end
      DATA: begin
        ce     = 1'b1;
        sclk   = (div_cnt >= DIV_HALF);
        sdo_oe = !rw_q;
        wr_ack = !rw_q && byte_end && !last_byte && !abort_req;
      end
      default: ce = 1'b0;
    endcase
    sdo = sdo_oe & tx_sh[0];
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      rw_q     <= 1'b0;
      len_q    <= 8'd0;
      tx_sh    <= 8'd0;
      rx_sh    <= 8'd0;
      rd_byte  <= 8'd0;
      rd_valid <= 1'b0;
      div_cnt  <= 9'd0;
      bit_cnt  <= 3'd0;
      byte_cnt <= 8'd0;
      cyc_cnt  <= 8'd0;
    end else begin
      rd_valid <= 1'b0;
      if (state == IDLE && start) begin
        rw_q  <= rw;
        tx_sh <= cmd;
        if (len == 8'd0)        len_q <= 8'd1;
        else if (len > MAX_LEN) len_q <= MAX_LEN;
        else                    len_q <= len;
      end else if (wr_ack) begin
        tx_sh <= wr_byte;
      end else if (period_end) begin
        tx_sh <= {1'b0, tx_sh[7:1]};
      end
      if (sample_now && !abort_req) begin
        rx_sh <= {sdi, rx_sh[7:1]};
        if (bit_cnt == 3'd7) begin
          rd_byte  <= {sdi, rx_sh[7:1]};
          rd_valid <= 1'b1;
        end
      end
      // every state entry starts its counters from zero
      if (state_next != state) begin
        div_cnt  <= 9'd0;
        bit_cnt  <= 3'd0;
        byte_cnt <= 8'd0;
        cyc_cnt  <= 8'd0;
      end else begin
        if (state == SETUP || state == HOLD) cyc_cnt <= cyc_cnt + 8'd1;
        if (shifting) begin
          div_cnt <= period_end ? 9'd0 : div_cnt + 9'd1;
          if (period_end) bit_cnt <= bit_cnt + 3'd1;
          if (byte_end) byte_cnt <= byte_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi3w_burst.sv
// Bench for spi3w_burst: random bursts checked against a bus-level monitor and a transaction model.
// Two instances (CLK_DIV 1 and 3) share the stimulus; sel picks which one is started and observed.
module tb_spi3w_burst;

  localparam int SETUP_CYC = 4;
  localparam int HOLD_CYC  = 4;
  localparam int MAX_BYTES = 31;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b0, start = 1'b0, rw = 1'b0, sdi = 1'b0, sel = 1'b0;
  logic [7:0] cmd = 8'd0, len = 8'd0, wr_byte = 8'd0;
`ifdef SPI3W_ABORT_EN
  logic       abort = 1'b0;
`endif

  logic [1:0]      wr_ack_v, rd_valid_v, busy_v, done_v, ce_v, sclk_v, sdo_v, sdo_oe_v;
  logic [1:0][7:0] rd_byte_v;
  logic            wr_ack, rd_valid, busy, done, ce, sclk, sdo, sdo_oe;
  logic [7:0]      rd_byte;

  assign wr_ack   = wr_ack_v[sel];
  assign rd_valid = rd_valid_v[sel];
  assign busy     = busy_v[sel];
  assign done     = done_v[sel];
  assign ce       = ce_v[sel];
  assign sclk     = sclk_v[sel];
  assign sdo      = sdo_v[sel];
  assign sdo_oe   = sdo_oe_v[sel];
  assign rd_byte  = rd_byte_v[sel];

  spi3w_burst #(.CLK_DIV(1), .MAX_BYTES(MAX_BYTES), .SETUP_CYC(SETUP_CYC), .HOLD_CYC(HOLD_CYC)) dut (
    .sys_clk(sys_clk), .rst(rst), .start(start && !sel), .rw(rw), .cmd(cmd), .len(len),
    .wr_byte(wr_byte), .wr_ack(wr_ack_v[0]), .rd_byte(rd_byte_v[0]), .rd_valid(rd_valid_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .ce(ce_v[0]), .sclk(sclk_v[0]), .sdo(sdo_v[0]),
    .sdo_oe(sdo_oe_v[0]), .sdi(sdi)
`ifdef SPI3W_ABORT_EN
    , .abort(abort && !sel)
`endif
  );

  spi3w_burst #(.CLK_DIV(3), .MAX_BYTES(MAX_BYTES), .SETUP_CYC(SETUP_CYC), .HOLD_CYC(HOLD_CYC)) dut3 (
    .sys_clk(sys_clk), .rst(rst), .start(start && sel), .rw(rw), .cmd(cmd), .len(len),
    .wr_byte(wr_byte), .wr_ack(wr_ack_v[1]), .rd_byte(rd_byte_v[1]), .rd_valid(rd_valid_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .ce(ce_v[1]), .sclk(sclk_v[1]), .sdo(sdo_v[1]),
    .sdo_oe(sdo_oe_v[1]), .sdi(sdi)
`ifdef SPI3W_ABORT_EN
    , .abort(abort && sel)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;
  int cdiv = 1;

  logic [7:0] wr_data[$];
  logic [7:0] rd_data[$];
  logic [7:0] mon_tx[$];
  logic [7:0] mon_rx[$];
  int mon_acks, mon_done_cyc, mon_done_cnt, mon_rises, mon_bad, mon_ce_hi;
  int mon_first_rise, mon_last_rise, mon_post_rst;

  function automatic int eff_len(input int l);
    if (l == 0) return 1;
    if (l > MAX_BYTES) return MAX_BYTES;
    return l;
  endfunction

  // start sampled at cycle 0: SETUP, 8 command bits, 8*n data bits, HOLD, then DONE
  function automatic int exp_done(input int n);
    return SETUP_CYC + 16 * cdiv * (n + 1) + HOLD_CYC + 1;
  endfunction

  task automatic make_data(input int n);
    wr_data.delete();
    rd_data.delete();
    for (int i = 0; i < n; i++) begin
      wr_data.push_back(8'($urandom));
      rd_data.push_back(8'($urandom));
    end
  endtask

  // Drives one transaction and records what the bus did. ev: 0 none, 1 start while busy,
  // 2 reset, 3 abort, each injected in cycle ev_cyc.
  task automatic run_txn(input logic t_rw, input logic [7:0] t_cmd, input logic [7:0] t_len,
                         input int ev, input int ev_cyc);
    logic [7:0] sh, bsel;
    logic       prev_sclk, prev_sdo, fell;
    int         nbits, hi_run, lo_run, stop_at, k;
    mon_tx.delete();
    mon_rx.delete();
    mon_acks = 0; mon_done_cyc = -1; mon_done_cnt = 0; mon_rises = 0; mon_bad = 0;
    mon_ce_hi = 0; mon_first_rise = -1; mon_last_rise = -1; mon_post_rst = -1;
    sh = 8'd0; prev_sclk = 1'b0; prev_sdo = 1'b0; fell = 1'b0;
    nbits = 0; hi_run = 0; lo_run = 0; stop_at = 4000;
    rw = t_rw; cmd = t_cmd; len = t_len; start = 1'b1;
    wr_byte = (wr_data.size() > 0) ? wr_data[0] : 8'h00;
    for (int cyc = 1; cyc <= stop_at; cyc++) begin
      @(negedge sys_clk);
      start = 1'b0;
      rst = 1'b0;
`ifdef SPI3W_ABORT_EN
      abort = (ev == 3 && cyc == ev_cyc);
`endif
      if (ev == 1 && cyc == ev_cyc) begin
        start = 1'b1; cmd = ~t_cmd; len = 8'd3; rw = ~t_rw;
      end
      if (ev == 2 && cyc == ev_cyc) begin
        rst = 1'b1;
        stop_at = cyc + 12;
      end
      if (ev == 2 && cyc == ev_cyc + 1) mon_post_rst = int'({ce, busy, done, sclk});
      if (sclk && !prev_sclk) begin
        mon_rises++;
        if (mon_first_rise < 0) mon_first_rise = cyc;
        mon_last_rise = cyc;
        sh = {sdo, sh[7:1]};
        nbits++;
        if (nbits % 8 == 0) mon_tx.push_back(sh);
        if (ev <= 1 && fell && lo_run != cdiv) mon_bad++;
        hi_run = 0;
      end
      if (!sclk && prev_sclk) begin
        fell = 1'b1;
        if (ev <= 1 && hi_run != cdiv) mon_bad++;
        lo_run = 0;
      end
      if (sclk) hi_run++;
      else lo_run++;
      if (sclk && prev_sclk && sdo != prev_sdo) mon_bad++;
      if (!sdo_oe && sdo) mon_bad++;
      if (t_rw && (mon_rises > 8 || (mon_rises == 8 && !sclk)) && sdo_oe) mon_bad++;
      if (!busy && ce) mon_bad++;
      if (ce) mon_ce_hi++;
      if (mon_done_cnt > 0 && cyc == mon_done_cyc + 1 && busy) mon_bad++;
      if (done) begin
        mon_done_cnt++;
        if (mon_done_cyc < 0) mon_done_cyc = cyc;
        if (!busy || ce) mon_bad++;
        if (stop_at > cyc + 1) stop_at = cyc + 1;
      end
      k = mon_rises - 8;
      if (t_rw && k >= 0 && k < 8 * rd_data.size()) begin
        bsel = rd_data[k / 8];
        sdi = bsel[k % 8];
      end else begin
        sdi = 1'b0;
      end
      wr_byte = (mon_acks < wr_data.size()) ? wr_data[mon_acks] : 8'h00;
      if (wr_ack) mon_acks++;
      if (rd_valid) mon_rx.push_back(rd_byte);
      prev_sclk = sclk;
      prev_sdo = sdo;
    end
  endtask

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      rst = 1'b1;
      repeat (2) @(negedge sys_clk);
      checks++;
      if ({ce, sclk, sdo, sdo_oe, wr_ack, rd_valid, busy, done} !== 8'h00) begin
        errors++;
        $display("[TB] FAIL reset_ctrl%0d: got %b, expected 00000000", s,
                 {ce, sclk, sdo, sdo_oe, wr_ack, rd_valid, busy, done});
      end
      checks++;
      if (rd_byte !== 8'h00) begin
        errors++;
        $display("[TB] FAIL reset_rd_byte%0d: got %h, expected 00", s, rd_byte);
      end
      rst = 1'b0;
      @(negedge sys_clk);
    end
    sel = 1'b0;
  endtask

  task automatic test_write_fixed();
    sel = 1'b0; cdiv = 1;
    wr_data.delete(); rd_data.delete();
    wr_data.push_back(8'h00);
    run_txn(1'b0, 8'h8E, 8'd1, 0, 0);
    checks++;
    if (mon_done_cnt != 1 || mon_done_cyc != exp_done(1)) begin
      errors++;
      $display("[TB] FAIL wr_done: got cycle %0d count %0d, expected cycle %0d count 1",
               mon_done_cyc, mon_done_cnt, exp_done(1));
    end
    checks++;
    if (mon_rises != 16) begin
      errors++; $display("[TB] FAIL wr_pulses: got %0d, expected 16", mon_rises);
    end
    checks++;
    if (mon_tx.size() != 2 || mon_tx[0] !== 8'h8E || mon_tx[1] !== 8'h00) begin
      errors++; $display("[TB] FAIL wr_stream: got %p, expected '{8e, 00}", mon_tx);
    end
    checks++;
    if (mon_acks != 1) begin
      errors++; $display("[TB] FAIL wr_acks: got %0d, expected 1", mon_acks);
    end
    checks++;
    if (mon_first_rise != 1 + SETUP_CYC + cdiv || mon_ce_hi != exp_done(1) - 1) begin
      errors++;
      $display("[TB] FAIL wr_framing: first rise %0d ce cycles %0d, expected %0d and %0d",
               mon_first_rise, mon_ce_hi, 1 + SETUP_CYC + cdiv, exp_done(1) - 1);
    end
    checks++;
    if (mon_bad != 0) begin
      errors++; $display("[TB] FAIL wr_protocol: got %0d violations, expected 0", mon_bad);
    end
  endtask

  task automatic test_read_fixed();
    sel = 1'b0; cdiv = 1;
    wr_data.delete(); rd_data.delete();
    for (int i = 1; i <= 8; i++) rd_data.push_back(8'(i * 8'h11));
    run_txn(1'b1, 8'hBF, 8'd8, 0, 0);
    checks++;
    if (mon_rx.size() != 8) begin
      errors++; $display("[TB] FAIL rd_count: got %0d, expected 8", mon_rx.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (mon_rx[i] !== rd_data[i]) begin
          errors++; $display("[TB] FAIL rd_byte%0d: got %h, expected %h", i, mon_rx[i], rd_data[i]);
        end
      end
    end
    checks++;
    if (mon_tx.size() != 9 || mon_tx[0] !== 8'hBF) begin
      errors++; $display("[TB] FAIL rd_cmd: got %p, expected bf then 8 bytes", mon_tx);
    end
    checks++;
    if (mon_done_cyc != exp_done(8) || mon_acks != 0 || mon_bad != 0) begin
      errors++;
      $display("[TB] FAIL rd_frame: done %0d acks %0d violations %0d, expected %0d, 0, 0",
               mon_done_cyc, mon_acks, mon_bad, exp_done(8));
    end
  endtask

  task automatic test_clamp();
    sel = 1'b0; cdiv = 1;
    make_data(1);
    run_txn(1'b0, 8'h5A, 8'd0, 0, 0);
    checks++;
    if (mon_acks != 1 || mon_rises != 16 || mon_done_cyc != exp_done(1)) begin
      errors++;
      $display("[TB] FAIL clamp_zero: acks %0d pulses %0d done %0d, expected 1, 16, %0d",
               mon_acks, mon_rises, mon_done_cyc, exp_done(1));
    end
    make_data(MAX_BYTES);
    run_txn(1'b1, 8'hC3, 8'd200, 0, 0);
    checks++;
    if (mon_rx.size() != MAX_BYTES || mon_done_cyc != exp_done(MAX_BYTES)) begin
      errors++;
      $display("[TB] FAIL clamp_max: bytes %0d done %0d, expected %0d and %0d",
               mon_rx.size(), mon_done_cyc, MAX_BYTES, exp_done(MAX_BYTES));
    end else begin
      for (int i = 0; i < MAX_BYTES; i++) begin
        checks++;
        if (mon_rx[i] !== rd_data[i]) begin
          errors++; $display("[TB] FAIL clamp_byte%0d: got %h, expected %h", i, mon_rx[i], rd_data[i]);
        end
      end
    end
  endtask

  // consecutive calls also start each burst in the first cycle after DONE
  task automatic test_random();
    logic trw;
    logic [7:0] tcmd, tlen, e;
    int n;
    sel = 1'b0; cdiv = 1;
    for (int it = 0; it < 8; it++) begin
      trw  = 1'($urandom_range(0, 1));
      tcmd = 8'($urandom);
      tlen = (it == 5) ? 8'($urandom_range(32, 255)) : 8'($urandom_range(0, 6));
      n = eff_len(int'(tlen));
      make_data(n);
      run_txn(trw, tcmd, tlen, 0, 0);
      checks++;
      if (mon_done_cnt != 1 || mon_done_cyc != exp_done(n)) begin
        errors++;
        $display("[TB] FAIL rand%0d_done: got cycle %0d count %0d, expected cycle %0d",
                 it, mon_done_cyc, mon_done_cnt, exp_done(n));
      end
      checks++;
      if (mon_acks != (trw ? 0 : n) || mon_bad != 0) begin
        errors++;
        $display("[TB] FAIL rand%0d_acks: acks %0d violations %0d, expected %0d and 0",
                 it, mon_acks, mon_bad, trw ? 0 : n);
      end
      checks++;
      if (mon_tx.size() != n + 1) begin
        errors++; $display("[TB] FAIL rand%0d_txlen: got %0d, expected %0d", it, mon_tx.size(), n + 1);
      end else begin
        for (int i = 0; i <= n; i++) begin
          e = (i == 0) ? tcmd : (trw ? 8'h00 : wr_data[i - 1]);
          checks++;
          if (mon_tx[i] !== e) begin
            errors++; $display("[TB] FAIL rand%0d_tx%0d: got %h, expected %h", it, i, mon_tx[i], e);
          end
        end
      end
      checks++;
      if (mon_rx.size() != (trw ? n : 0)) begin
        errors++; $display("[TB] FAIL rand%0d_rxlen: got %0d, expected %0d", it, mon_rx.size(), trw ? n : 0);
      end else begin
        for (int i = 0; i < mon_rx.size(); i++) begin
          checks++;
          if (mon_rx[i] !== rd_data[i]) begin
            errors++; $display("[TB] FAIL rand%0d_rx%0d: got %h, expected %h", it, i, mon_rx[i], rd_data[i]);
          end
        end
      end
    end
  endtask

  task automatic test_clkdiv3();
    logic [7:0] tcmd;
    sel = 1'b1; cdiv = 3;
    tcmd = 8'($urandom);
    make_data(3);
    run_txn(1'b0, tcmd, 8'd3, 1, 30);
    checks++;
    if (mon_done_cnt != 1 || mon_done_cyc != exp_done(3)) begin
      errors++;
      $display("[TB] FAIL div3_done: got cycle %0d count %0d, expected cycle %0d count 1",
               mon_done_cyc, mon_done_cnt, exp_done(3));
    end
    checks++;
    if (mon_bad != 0 || mon_first_rise != 1 + SETUP_CYC + cdiv) begin
      errors++;
      $display("[TB] FAIL div3_phases: violations %0d first rise %0d, expected 0 and %0d",
               mon_bad, mon_first_rise, 1 + SETUP_CYC + cdiv);
    end
    checks++;
    if (mon_acks != 3 || mon_tx.size() != 4 || mon_tx[0] !== tcmd || mon_tx[3] !== wr_data[2]) begin
      errors++;
      $display("[TB] FAIL div3_stream: acks %0d got %p, expected 3 acks and cmd %h", mon_acks, mon_tx, tcmd);
    end
    make_data(2);
    run_txn(1'b1, 8'h3C, 8'd2, 0, 0);
    checks++;
    if (mon_rx.size() != 2 || mon_rx[0] !== rd_data[0] || mon_rx[1] !== rd_data[1]) begin
      errors++; $display("[TB] FAIL div3_read: got %p, expected %p", mon_rx, rd_data);
    end
    checks++;
    if (mon_done_cyc != exp_done(2) || mon_bad != 0) begin
      errors++;
      $display("[TB] FAIL div3_rdframe: done %0d violations %0d, expected %0d and 0",
               mon_done_cyc, mon_bad, exp_done(2));
    end
    sel = 1'b0; cdiv = 1;
  endtask

  task automatic test_reset_mid();
    sel = 1'b0; cdiv = 1;
    make_data(4);
    run_txn(1'b0, 8'h77, 8'd4, 2, 30);
    checks++;
    if (mon_post_rst != 0) begin
      errors++; $display("[TB] FAIL rstmid_outputs: got {ce,busy,done,sclk}=%0d, expected 0", mon_post_rst);
    end
    checks++;
    if (mon_done_cnt != 0) begin
      errors++; $display("[TB] FAIL rstmid_nodone: got %0d done pulses, expected 0", mon_done_cnt);
    end
    make_data(2);
    run_txn(1'b0, 8'h19, 8'd2, 0, 0);
    checks++;
    if (mon_done_cyc != exp_done(2) || mon_acks != 2 || mon_tx.size() != 3 || mon_tx[0] !== 8'h19) begin
      errors++;
      $display("[TB] FAIL rstmid_after: done %0d acks %0d tx %p, expected %0d, 2, cmd 19",
               mon_done_cyc, mon_acks, mon_tx, exp_done(2));
    end
  endtask

`ifdef SPI3W_ABORT_EN
  // the third data byte occupies cycles 53..68 here; abort lands inside it
  task automatic test_abort();
    sel = 1'b0; cdiv = 1;
    make_data(6);
    run_txn(1'b0, 8'hA5, 8'd6, 3, 58);
    checks++;
    if (mon_acks != 3) begin
      errors++; $display("[TB] FAIL abort_acks: got %0d, expected 3", mon_acks);
    end
    checks++;
    if (mon_done_cnt != 1 || mon_done_cyc != 58 + HOLD_CYC + 1) begin
      errors++;
      $display("[TB] FAIL abort_done: got cycle %0d count %0d, expected cycle %0d",
               mon_done_cyc, mon_done_cnt, 58 + HOLD_CYC + 1);
    end
    checks++;
    if (mon_last_rise > 58 || mon_ce_hi != 58 + HOLD_CYC) begin
      errors++;
      $display("[TB] FAIL abort_bus: last rise %0d ce cycles %0d, expected <=58 and %0d",
               mon_last_rise, mon_ce_hi, 58 + HOLD_CYC);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write_fixed();
    test_read_fixed();
    test_clamp();
    test_random();
    test_clkdiv3();
    test_reset_mid();
`ifdef SPI3W_ABORT_EN
    test_abort();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
